hilo_multdiv: RTL
=================

# hilo_multdiv

Sequential multiply/divide unit that owns the architectural HI and LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the control path.
- Computes products and quotients iteratively, one bit per cycle.
- Presents HI/LO continuously to the datapath for MFHI/MFLO reads.
- Sits beside the single-cycle ALU; `busy` stalls the pipeline while an operation is in flight.

## Interface

Parameters:
- `WIDTH`, 32, operand and HI/LO width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request valid; sampled only when `busy`=0.
- `op`  in  3  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP.
- `a`  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `b`  in  WIDTH  rt operand: multiplier or divisor.
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO now hold the new result.
- `hi`  out  WIDTH  architectural HI register.
- `lo`  out  WIDTH  architectural LO register.

## Operation

- Reset: `hi`=0, `lo`=0, `busy`=0, `done`=0, FSM=IDLE, internal accumulators cleared.
- FSM states and transitions:
  - IDLE → MUL on accepted `start` with op MULT or MULTU.
  - IDLE → DIV on accepted `start` with op DIV or DIVU.
  - MUL/DIV → IDLE after WIDTH iterations.
- Accept rule:
  - `start`=1 while `busy`=0 is accepted.
  - `start` while `busy`=1 is ignored with no queueing; the control path must stall.
- MTHI/MTLO:
  - Accepted in IDLE; write `hi` (MTHI) or `lo` (MTLO) with `a` at the accept edge.
  - No `busy`, no `done`.
- Signed ops (MULT/DIV):
  - At accept, latch |a|, |b|, and the result signs.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Negation is applied at writeback.
- MUL: shift-add, 2·WIDTH-bit accumulator. `hi` = product[2W-1:W], `lo` = product[W-1:0].
- DIV: restoring division, one quotient bit per cycle. `lo` = quotient, `hi` = remainder (truncating division).
- Divide by zero: `lo` = all ones, `hi` = `a` (dividend, unmodified). Full latency still applies.
- Signed overflow (-2^31 / -1): `lo` = 0x80000000, `hi` = 0.
- `hi`/`lo` hold their previous values throughout an operation and are written only at completion.
- NOP ops (0, 7) with `start` have no effect.

## Timing

- Latency: accept at edge E0; `busy`=1 after E0 through E31.
- Completion at edge E32:
  - `hi`/`lo` written.
  - `busy`→0.
  - `done`=1 for the single cycle after E32.
- New `start` may be accepted in the same cycle `done` is high, giving back-to-back throughput of one op per 33 cycles.
- MTHI/MTLO: result visible in the cycle after the accept edge.
- Reset mid-operation:
  - Aborts the operation; outputs return to reset values at the next edge.
  - No `done` is issued.
- `done` and `busy` are never both 1.

## Configuration

- `HILO_DIV_EN` defined: DIV/DIVU implemented as above.
- `HILO_DIV_EN` undefined:
  - Divider datapath and DIV state removed.
  - DIV/DIVU are accepted: `busy` stays 0, `done` pulses in the next cycle, `hi`/`lo` unchanged.
  - MUL and MTHI/MTLO are unaffected.

## Test plan

- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high exactly 32 cycles; `done` one cycle.
- MULT a=0xFFFFFFFD (-3), b=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV cases:
  - DIV a=0xFFFFFFF9 (-7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU a=7, b=0 → `lo`=0xFFFFFFFF, `hi`=7, after 32 cycles. Without `HILO_DIV_EN`: `done` next cycle, `hi`/`lo` unchanged.
- MTHI/busy handshake:
  - MTHI a=0x12345678 in IDLE → `hi`=0x12345678 next cycle, `lo` unchanged, no `done`.
  - Then MULTU 3×5 with a second MULTU `start` on cycle 5 → second request ignored; final `hi`=0, `lo`=15.
- Reset asserted on cycle 10 of MULTU 0xFFFF×0xFFFF (after prior `hi`=`lo`=0x55) → next cycle `busy`=0, `hi`=`lo`=0; no `done` for 40 cycles.

Source files
------------

// File: rtl/hilo_multdiv_if.sv
`default_nettype none
// ============================================================================
// Module   : hilo_multdiv_if
// Brief    : Request/result bundle between the control path and the HI/LO
//            multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
interface hilo_multdiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input  busy, done, hi, lo);
    modport slave  (input  start, op, a, b, output busy, done, hi, lo);
endinterface
`default_nettype wire

// File: rtl/hilo_multdiv.sv
`default_nettype none
// ============================================================================
// Module   : hilo_multdiv
// Brief    : Iterative (1 bit/cycle) multiply/divide unit owning HI/LO.
//            Define HILO_DIV_EN to build the restoring divider; without it
//            DIV/DIVU complete the next cycle with HI/LO untouched.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_multdiv #(
    parameter int WIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     reset,
    hilo_multdiv_if.slave bus
);
    localparam int         c_CW       = $clog2(WIDTH);
    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_MUL   = 2'd1;
`ifdef HILO_DIV_EN
    localparam logic [1:0] c_ST_DIV   = 2'd2;
`endif

    logic [1:0]         r_state;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opb;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] r_acc;     // {partial product, multiplier} or {remainder, dividend/quotient}
    logic [c_CW-1:0]    r_cnt;
    logic               r_qneg;    // negate product / quotient at writeback

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_last;
`ifdef HILO_DIV_EN
    logic               r_rneg;
    logic               w_div0;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
`endif

    always_comb begin
        w_signed   = (bus.op == c_OP_MULT) || (bus.op == c_OP_DIV);
        w_a_neg    = w_signed & bus.a[WIDTH-1];
        w_b_neg    = w_signed & bus.b[WIDTH-1];
        w_abs_a    = w_a_neg ? -bus.a : bus.a;
        w_abs_b    = w_b_neg ? -bus.b : bus.b;
        w_last     = (r_cnt == c_CW'(WIDTH - 1));
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
        w_mul_next = {w_sum, r_acc[WIDTH-1:1]};
        w_prod     = r_qneg ? -w_mul_next : w_mul_next;
`ifdef HILO_DIV_EN
        w_div0     = (bus.b == '0);
        w_diff     = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opb};
        w_div_next = w_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        w_quo      = r_qneg ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
        w_rem      = r_rneg ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_qneg  <= 1'b0;
`ifdef HILO_DIV_EN
            r_rneg  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            c_OP_MULT, c_OP_MULTU: begin
                                r_state <= c_ST_MUL;
                                r_busy  <= 1'b1;
                                r_cnt   <= '0;
                                r_opb   <= w_abs_a;
                                r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
                                r_qneg  <= w_a_neg ^ w_b_neg;
                            end
                            c_OP_DIV, c_OP_DIVU: begin
`ifdef HILO_DIV_EN
                                r_state <= c_ST_DIV;
                                r_busy  <= 1'b1;
                                r_cnt   <= '0;
                                r_opb   <= w_abs_b;
                                // Dividing the raw dividend by zero leaves an all-ones
                                // quotient and the dividend as remainder, so no special case.
                                r_acc   <= {{WIDTH{1'b0}}, w_div0 ? bus.a : w_abs_a};
                                r_qneg  <= ~w_div0 & (w_a_neg ^ w_b_neg);
                                r_rneg  <= ~w_div0 & w_a_neg;
`else
                                r_done  <= 1'b1;
`endif
                            end
                            c_OP_MTHI: r_hi <= bus.a;
                            c_OP_MTLO: r_lo <= bus.a;
                            default: ;
                        endcase
                    end
                end
                c_ST_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + c_CW'(1);
                    if (w_last) begin
                        r_hi    <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo    <= w_prod[WIDTH-1:0];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                end
`ifdef HILO_DIV_EN
                c_ST_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + c_CW'(1);
                    if (w_last) begin
                        r_hi    <= w_rem;
                        r_lo    <= w_quo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule
`default_nettype wire
